// File: rtl/imem_program_loader.sv
// Assembles big-endian bytes into instruction words and writes them to
// consecutive instruction-memory addresses until HALT_WORD or memory full.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte check.
module imem_program_loader #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_BYTE   = 8,
  parameter int                 N_ADDR    = 2048,
  parameter int                 NB_ADDR   = $clog2(N_ADDR + 1),
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_wr_data,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic               o_wr_enable,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic               o_chk_error,
`endif
  output logic [NB_ADDR:0]   o_word_count
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, RECEIVE, DONE, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECEIVE, DONE} state_t;
`endif

  state_t                      r_state;
  state_t                      w_next_state;
  logic [NB_DATA-NB_BYTE-1:0]  r_shift;
  logic [NB_CNT-1:0]           r_byte_cnt;
  logic [NB_ADDR-1:0]          r_addr;
  logic [NB_DATA-1:0]          w_assembled;
  logic                        w_rx_accept;
  logic                        w_word_done;
  logic                        w_start;
  logic                        w_is_halt;
  logic                        w_is_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]                  r_sum;
`endif

  assign w_assembled = {r_shift, i_rx_data};
  assign w_rx_accept = (r_state == RECEIVE) && i_rx_valid;
  assign w_word_done = w_rx_accept && (r_byte_cnt == NB_CNT'(N_BYTES - 1));
  assign w_start     = i_start && ((r_state == IDLE) || (r_state == DONE));
  // End-of-load decisions are taken in the write cycle from the registered
  // write outputs, so o_done rises the cycle after o_wr_enable.
  assign w_is_halt   = (o_wr_data == HALT_WORD);
  assign w_is_last   = (o_wr_addr == NB_ADDR'(N_ADDR - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = RECEIVE;
      RECEIVE: begin
        if (o_wr_enable) begin
          if (w_is_halt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_next_state = CHECK;
`else
            w_next_state = DONE;
`endif
          end else if (w_is_last) begin
            w_next_state = DONE;
          end
        end
      end
      DONE:    if (i_start) w_next_state = RECEIVE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK:   if (i_rx_valid) w_next_state = DONE;
`endif
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_addr       <= '0;
      o_wr_data    <= '0;
      o_wr_addr    <= '0;
      o_wr_enable  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_wr_enable <= 1'b0;
      o_busy      <= (w_next_state == RECEIVE);
      o_done      <= (w_next_state == DONE);
      if (w_start) begin
        r_byte_cnt   <= '0;
        r_addr       <= '0;
        o_overflow   <= 1'b0;
        o_word_count <= '0;
      end
      if (w_rx_accept) begin
        r_shift    <= w_assembled[NB_DATA-NB_BYTE-1:0];
        r_byte_cnt <= w_word_done ? '0 : r_byte_cnt + NB_CNT'(1);
        if (w_word_done) begin
          o_wr_enable  <= 1'b1;
          o_wr_data    <= w_assembled;
          o_wr_addr    <= r_addr;
          r_addr       <= r_addr + NB_ADDR'(1);
          o_word_count <= o_word_count + (NB_ADDR+1)'(1);
        end
      end
      if ((r_state == RECEIVE) && o_wr_enable && !w_is_halt && w_is_last)
        o_overflow <= 1'b1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sum       <= '0;
      o_chk_error <= 1'b0;
    end else begin
      if (w_start) begin
        r_sum       <= '0;
        o_chk_error <= 1'b0;
      end else if (w_rx_accept) begin
        r_sum <= r_sum + 8'(i_rx_data);
      end
      if ((r_state == CHECK) && i_rx_valid)
        o_chk_error <= (8'(i_rx_data) != r_sum);
    end
  end
`endif

endmodule
